// File: rtl/uart_transmitter_if.sv
// ---------------------------------------------------------------------------
// uart_transmitter_if
// Byte handshake between an upstream producer and the UART transmitter.
//   i_TX_VALID  producer -> tx   a byte is waiting on i_DATA
//   i_DATA      producer -> tx   byte to send, held while valid and not ready
//   o_TX_READY  tx -> producer   holding register is empty
// Modports: master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_TX_VALID;
    logic [DATA_WIDTH-1:0] i_DATA;
    logic                  o_TX_READY;

    modport master (
        output i_TX_VALID,
        output i_DATA,
        input  o_TX_READY
    );

    modport slave (
        input  i_TX_VALID,
        input  i_DATA,
        output o_TX_READY
    );
endinterface

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Serialises bytes onto a UART line: one start bit (0), DATA_WIDTH data bits
// MSB first, STOP_BITS stop bits (1). One line bit per i_CLK_ENABLE tick.
// A one-entry holding register in front of the shift register lets a new
// byte start immediately after the last stop bit with no idle gap.
// Ports:
//   i_CLK         system clock, rising edge
//   i_RESET_N     synchronous active-low reset
//   i_CLK_ENABLE  baud tick; the FSM and line only advance when it is 1
//   tx_if         byte handshake (slave modport): i_TX_VALID, i_DATA, o_TX_READY
//   o_TX          registered serial line, idle high
//   o_BUSY        registered, 1 while a frame is in progress
//   o_TX_DONE     registered one-clock pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic              i_CLK,
    input  logic              i_RESET_N,
    input  logic              i_CLK_ENABLE,
    uart_transmitter_if.slave tx_if,
    output logic              o_TX,
    output logic              o_BUSY,
    output logic              o_TX_DONE
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  hold_full;
    logic [CNT_W-1:0]      bit_cnt;
    logic [1:0]            stop_cnt;

    assign tx_if.o_TX_READY = ~hold_full;

    // Acceptance and the hold->shift transfer never collide: acceptance
    // needs hold_full=0, the transfer needs hold_full=1. The FSM looks at
    // the registered hold_full, so a byte accepted on a tick edge waits for
    // the next tick before its start bit goes out.
    always_ff @(posedge i_CLK) begin
        if (!i_RESET_N) begin
            state     <= IDLE;
            hold_reg  <= '0;
            shift_reg <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            o_TX      <= 1'b1;
            o_BUSY    <= 1'b0;
            o_TX_DONE <= 1'b0;
        end else begin
            o_TX_DONE <= 1'b0;

            if (tx_if.i_TX_VALID && !hold_full) begin
                hold_reg  <= tx_if.i_DATA;
                hold_full <= 1'b1;
            end

            if (i_CLK_ENABLE) begin
                case (state)
                    IDLE: begin
                        o_TX   <= 1'b1;
                        o_BUSY <= 1'b0;
                        if (hold_full) begin
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                            o_TX      <= 1'b0;
                            o_BUSY    <= 1'b1;
                            state     <= START;
                        end
                    end
                    START: begin
                        o_TX      <= shift_reg[DATA_WIDTH-1];
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt   <= CNT_W'(1);
                        state     <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt < LAST_BIT) begin
                            o_TX      <= shift_reg[DATA_WIDTH-1];
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end else begin
                            o_TX     <= 1'b1;
                            stop_cnt <= 2'd1;
                            state    <= STOP;
                        end
                    end
                    STOP: begin
                        if (stop_cnt < LAST_STOP) begin
                            o_TX     <= 1'b1;
                            stop_cnt <= stop_cnt + 1'b1;
                        end else begin
                            o_TX_DONE <= 1'b1;
                            // A waiting byte goes straight into its start bit.
                            if (hold_full) begin
                                shift_reg <= hold_reg;
                                hold_full <= 1'b0;
                                o_TX      <= 1'b0;
                                state     <= START;
                            end else begin
                                o_TX   <= 1'b1;
                                o_BUSY <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: begin
                        o_TX   <= 1'b1;
                        o_BUSY <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter. One instance with STOP_BITS=1 carries
// most sequences; a second with STOP_BITS=2 covers the long stop period.
// Expected line levels are hand-written per tick (start, data MSB first,
// stop, then the idle/next-frame level on the tick that ends the frame).
// ---------------------------------------------------------------------------
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    logic tx, busy, done;
    logic tx2, busy2, done2;

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    int acc_at9  = 0;
    int base_acc = 0;

    logic [7:0]  offer_q[$];
    logic [0:40] seq;
    logic [0:11] line2;
    logic [7:0]  rnd;

    typedef struct {
        logic [7:0]  data;
        logic [0:10] line;
    } frame_vec_t;

    frame_vec_t vecs[4];

    uart_transmitter_if #(.DATA_WIDTH(8)) tx_if ();
    uart_transmitter_if #(.DATA_WIDTH(8)) tx2_if ();

    uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
        .i_CLK        (clk),
        .i_RESET_N    (rst_n),
        .i_CLK_ENABLE (clk_en),
        .tx_if        (tx_if),
        .o_TX         (tx),
        .o_BUSY       (busy),
        .o_TX_DONE    (done)
    );

    uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .i_CLK        (clk),
        .i_RESET_N    (rst_n),
        .i_CLK_ENABLE (clk_en),
        .tx_if        (tx2_if),
        .o_TX         (tx2),
        .o_BUSY       (busy2),
        .o_TX_DONE    (done2)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue a byte for the producer; valid stays high until the queue drains.
    task automatic offer(input logic [7:0] b);
        offer_q.push_back(b);
        tx_if.i_TX_VALID = 1'b1;
        tx_if.i_DATA     = offer_q[0];
    endtask

    // One clock with the given tick value; outputs are read 1 ns after the edge.
    task automatic apply_stimulus(input logic en);
        logic acc;
        clk_en = en;
        acc = rst_n && tx_if.i_TX_VALID && tx_if.o_TX_READY;
        @(posedge clk);
        #1;
        if (acc) begin
            accepted++;
            void'(offer_q.pop_front());
            if (offer_q.size() > 0) tx_if.i_DATA = offer_q[0];
            else tx_if.i_TX_VALID = 1'b0;
        end
    endtask

    // n ticks, three idle clocks after each (stall_at gets twenty).
    // Frames are ten ticks long, so done is expected on every tenth tick.
    task automatic run_seq(input logic [0:40] s, input int n, input int busy_until,
                           input int stall_at, input string name);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b1);
            if (i == 9) acc_at9 = accepted;
            check_output($sformatf("%s_tx%0d", name, i), tx, s[i]);
            check_output($sformatf("%s_busy%0d", name, i), busy, (i < busy_until));
            check_output($sformatf("%s_done%0d", name, i), done, (i > 0 && i % 10 == 0));
            for (int k = 0; k < ((i == stall_at) ? 20 : 3); k++) begin
                apply_stimulus(1'b0);
                check_output($sformatf("%s_hold%0d", name, i), tx, s[i]);
                check_output($sformatf("%s_donelow%0d", name, i), done, 1'b0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 11'b0_10100101_1_1};
        vecs[1] = '{8'h00, 11'b0_00000000_1_1};
        vecs[2] = '{8'hFF, 11'b0_11111111_1_1};
        vecs[3] = '{8'h55, 11'b0_01010101_1_1};

        rst_n = 1'b0;
        clk_en = 1'b0;
        tx_if.i_TX_VALID  = 1'b0;
        tx_if.i_DATA      = 8'h00;
        tx2_if.i_TX_VALID = 1'b0;
        tx2_if.i_DATA     = 8'h00;

        // Reset state
        repeat (2) apply_stimulus(1'b0);
        check_output("rst_tx", tx, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_ready", tx_if.o_TX_READY, 1'b1);
        check_output("rst_tx2", tx2, 1'b1);
        check_output("rst_ready2", tx2_if.o_TX_READY, 1'b1);
        rst_n = 1'b1;
        apply_stimulus(1'b0);

        // Single frames; the last vector is accepted on a tick edge and must
        // still wait for the following tick before its start bit.
        for (int v = 0; v < 4; v++) begin
            offer(vecs[v].data);
            apply_stimulus(v == 3);
            check_output($sformatf("vec%0d_acc_tx", v), tx, 1'b1);
            check_output($sformatf("vec%0d_acc_busy", v), busy, 1'b0);
            check_output($sformatf("vec%0d_acc_ready", v), tx_if.o_TX_READY, 1'b0);
            seq = '1;
            seq[0:10] = vecs[v].line;
            run_seq(seq, 11, 10, -1, $sformatf("vec%0d", v));
        end

        // Back-to-back 0x00 then 0xFF: no idle tick between frames
        offer(8'h00);
        offer(8'hFF);
        apply_stimulus(1'b0);
        seq = '1;
        seq[0:20] = 21'b0_00000000_1_0_11111111_1_1;
        run_seq(seq, 21, 20, -1, "b2b");

        // Two stop bits on the second instance
        tx2_if.i_TX_VALID = 1'b1;
        tx2_if.i_DATA     = 8'h3C;
        apply_stimulus(1'b0);
        tx2_if.i_TX_VALID = 1'b0;
        check_output("stop2_ready", tx2_if.o_TX_READY, 1'b0);
        line2 = 12'b0_00111100_1_1_1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1);
            check_output($sformatf("stop2_tx%0d", i), tx2, line2[i]);
            check_output($sformatf("stop2_busy%0d", i), busy2, (i < 11));
            check_output($sformatf("stop2_done%0d", i), done2, (i == 11));
            repeat (3) begin
                apply_stimulus(1'b0);
                check_output($sformatf("stop2_hold%0d", i), tx2, line2[i]);
                check_output($sformatf("stop2_donelow%0d", i), done2, 1'b0);
            end
        end

        // Reset during data bit 4 with a second byte waiting in hold
        offer(8'hA5);
        offer(8'h3C);
        apply_stimulus(1'b0);
        seq = '1;
        seq[0:4] = 5'b0_1010;
        run_seq(seq, 5, 5, -1, "pre_rst");
        check_output("pre_rst_ready", tx_if.o_TX_READY, 1'b0);
        rst_n = 1'b0;
        apply_stimulus(1'b0);
        check_output("midrst_tx", tx, 1'b1);
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_ready", tx_if.o_TX_READY, 1'b1);
        check_output("midrst_done", done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1);
            check_output($sformatf("postrst_tx%0d", i), tx, 1'b1);
            check_output($sformatf("postrst_busy%0d", i), busy, 1'b0);
            check_output($sformatf("postrst_done%0d", i), done, 1'b0);
        end
        offer(8'h55);
        apply_stimulus(1'b0);
        seq = '1;
        seq[0:10] = 11'b0_01010101_1_1;
        run_seq(seq, 11, 10, -1, "afterrst");

        // Valid held high with three bytes queued; a long tick-free stretch
        // in the middle of the first frame must freeze the line.
        base_acc = accepted;
        offer(8'h5A);
        offer(8'hC3);
        offer(8'h0F);
        apply_stimulus(1'b0);
        seq = '1;
        seq[0:30] = 31'b0_01011010_1_0_11000011_1_0_00001111_1_1;
        run_seq(seq, 31, 30, 4, "held");
        check_output("held_acc_frame1", acc_at9 - base_acc, 2);
        check_output("held_acc_total", accepted - base_acc, 3);
        check_output("held_valid_off", tx_if.i_TX_VALID, 1'b0);

        // Random byte, expected line built bit by bit from the byte value
        rnd = 8'($urandom_range(0, 255));
        seq = '1;
        seq[0] = 1'b0;
        for (int b = 0; b < 8; b++) seq[1 + b] = rnd[7 - b];
        offer(rnd);
        apply_stimulus(1'b0);
        run_seq(seq, 11, 10, -1, $sformatf("rand%02h", rnd));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
